// File: rtl/secuenciador_comparador_serial.sv
// secuenciador_comparador_serial
//
// Serial magnitude comparator controller. On an accepted start the operand
// pair is captured into shadow registers. The pair is then walked one bit per
// clock, MSB first. The first differing bit decides the result. When the walk
// ends, exactly one of mayor/menor/igual is driven and done pulses for one
// cycle. The result is held until the next accepted start.
//
// Build option:
//   COMPARA_SALIDA_TEMPRANA_EN - when defined, the comparison ends on the edge
//   that sees the first differing bit (latency K-j for first difference at
//   bit j). Equal operands still take K edges. When undefined, latency is
//   always K edges.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   start    request a comparison of the operands present this cycle
//   A_valor  operand A (K bits, unsigned), sampled on an accepted start
//   B_valor  operand B (K bits, unsigned), sampled on an accepted start
//   busy     high while a comparison is in progress
//   done     one-cycle pulse, result valid
//   mayor    A > B, registered
//   menor    A < B, registered
//   igual    A == B, registered
module secuenciador_comparador_serial #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] A_valor,
    input  logic [K-1:0] B_valor,
    output logic         busy,
    output logic         done,
    output logic         mayor,
    output logic         menor,
    output logic         igual
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {
        IDLE,
        COMPARA
    } state_t;

    state_t        state, state_n;
    logic [K-1:0]  a_sh, a_n;
    logic [K-1:0]  b_sh, b_n;
    logic [IW-1:0] idx, idx_n;
    logic          decided, decided_n;
    logic          pend, pend_n;      // 1 when the deciding bit had A=1, B=0
    logic          busy_n, done_n;
    logic          mayor_n, menor_n, igual_n;

    // Current bit pair and the result it implies together with history.
    logic bit_a, bit_b, diff;
    logic res_gt, res_lt, res_eq;
    logic fin;

    assign bit_a = a_sh[idx];
    assign bit_b = b_sh[idx];
    assign diff  = bit_a ^ bit_b;

    // A previously decided bit dominates; otherwise the current bit decides.
    assign res_gt = decided ? pend  : (diff & bit_a);
    assign res_lt = decided ? ~pend : (diff & bit_b);
    assign res_eq = ~decided & ~diff;

`ifdef COMPARA_SALIDA_TEMPRANA_EN
    assign fin = (idx == '0) || (!decided && diff);
`else
    assign fin = (idx == '0);
`endif

    always_comb begin
        state_n   = state;
        a_n       = a_sh;
        b_n       = b_sh;
        idx_n     = idx;
        decided_n = decided;
        pend_n    = pend;
        busy_n    = busy;
        done_n    = 1'b0;
        mayor_n   = mayor;
        menor_n   = menor;
        igual_n   = igual;

        case (state)
            IDLE: begin
                if (start) begin
                    a_n       = A_valor;
                    b_n       = B_valor;
                    idx_n     = IW'(K - 1);
                    decided_n = 1'b0;
                    pend_n    = 1'b0;
                    mayor_n   = 1'b0;
                    menor_n   = 1'b0;
                    igual_n   = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = COMPARA;
                end
            end

            COMPARA: begin
                if (!decided && diff) begin
                    decided_n = 1'b1;
                    pend_n    = bit_a;
                end
                if (fin) begin
                    mayor_n = res_gt;
                    menor_n = res_lt;
                    igual_n = res_eq;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - IW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            decided <= 1'b0;
            pend    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mayor   <= 1'b0;
            menor   <= 1'b0;
            igual   <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            decided <= decided_n;
            pend    <= pend_n;
            busy    <= busy_n;
            done    <= done_n;
            mayor   <= mayor_n;
            menor   <= menor_n;
            igual   <= igual_n;
        end
    end

    // Operand shadow registers; only meaningful after a capture, so no reset
    always_ff @(posedge clk) begin
        a_sh <= a_n;
        b_sh <= b_n;
    end

endmodule

// File: tb/tb_secuenciador_comparador_serial.sv
module tb_secuenciador_comparador_serial;

    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [K-1:0] A_valor;
    logic [K-1:0] B_valor;
    logic         busy, done, mayor, menor, igual;

    secuenciador_comparador_serial #(.K(K)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A_valor (A_valor),
        .B_valor (B_valor),
        .busy    (busy),
        .done    (done),
        .mayor   (mayor),
        .menor   (menor),
        .igual   (igual)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  res;      // {mayor, menor, igual}
        int unsigned acc;      // edge number that accepts the start
        int unsigned fin;      // edge number after which done is high
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: unsigned magnitude, latency from first differing MSB.
    function automatic logic [2:0] model_res(input logic [K-1:0] a, input logic [K-1:0] b);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return 3'b001;
    endfunction

    function automatic int model_lat(input logic [K-1:0] a, input logic [K-1:0] b);
`ifdef COMPARA_SALIDA_TEMPRANA_EN
        for (int i = K - 1; i >= 0; i--)
            if (a[i] != b[i]) return K - i;
`endif
        return K;
    endfunction

    // Issue one comparison, then keep the inputs noisy while it runs.
    // hold=1 keeps start asserted throughout; otherwise start toggles randomly.
    task automatic issue(input logic [K-1:0] a, input logic [K-1:0] b, input bit hold, input int gap);
        exp_t e;
        int   l;
        @(negedge clk);
        A_valor = a;
        B_valor = b;
        start   = 1'b1;
        l     = model_lat(a, b);
        e.res = model_res(a, b);
        e.acc = cyc + 1;
        e.fin = cyc + 1 + l;
        q.push_back(e);
        @(posedge clk);
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            A_valor = K'($urandom);
            B_valor = K'($urandom);
            start   = hold ? 1'b1 : 1'($urandom);
            @(posedge clk);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [2:0] last_res = 3'b000;
    initial begin
        logic [2:0] r;
        bit         exp_busy;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            r = {mayor, menor, igual};
            if (!rst_n) begin
                check("reset_busy", 32'(busy), 0);
                check("reset_done", 32'(done), 0);
                check("reset_res", 32'(r), 0);
                last_res = 3'b000;
            end else if (q.size() > 0 && cyc == q[0].fin) begin
                check("done_pulse", 32'(done), 1);
                check("busy_at_done", 32'(busy), 0);
                check("result", 32'(r), 32'(q[0].res));
                last_res = q[0].res;
                void'(q.pop_front());
            end else begin
                exp_busy = (q.size() > 0) && (cyc >= q[0].acc);
                check("no_done", 32'(done), 0);
                check("busy", 32'(busy), 32'(exp_busy));
                if (exp_busy) check("res_zero_busy", 32'(r), 0);
                else          check("res_hold", 32'(r), 32'(last_res));
            end
        end
    end

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        start   = 1'b0;
        A_valor = '0;
        B_valor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_state", 32'({busy, done, mayor, menor, igual}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'b1111, 4'b1111, 1'b0, 1);
        issue(4'b1101, 4'b1011, 1'b0, 1);
        issue(4'b0000, 4'b1011, 1'b0, 2);
        issue(4'b1101, 4'b1011, 1'b0, 0);   // noisy start/inputs while busy

        // Reset at the second COMPARA edge
        @(negedge clk);
        A_valor = 4'b1111;
        B_valor = 4'b0000;
        start   = 1'b1;
        e.res = model_res(4'b1111, 4'b0000);
        e.acc = cyc + 1;
        e.fin = cyc + 1 + model_lat(4'b1111, 4'b0000);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_out", 32'({busy, done, mayor, menor, igual}), 0);
        rst_n = 1'b1;
        issue(4'b0000, 4'b0000, 1'b0, 1);

        // Back-to-back with start held high
        issue(4'b1101, 4'b1011, 1'b1, 0);
        issue(4'b0000, 4'b1011, 1'b1, 0);
        issue(4'b0110, 4'b0110, 1'b1, 1);

        // Randomized
        for (int n = 0; n < 300; n++) begin
            logic [K-1:0] a, b;
            a = K'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : K'($urandom);
            issue(a, b, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

        @(negedge clk);
        start = 1'b0;
        repeat (K + 3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
